// File: rtl/final_mem.sv
// Byte-addressable 32-bit data RAM on the processor data bus: combinational
// little-endian reads, byte-lane-masked single-edge writes, never busy.
module final_mem #(
   parameter logic [31:0] BASE = 32'h0000_0000,
   parameter int unsigned SIZE = 1024
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic [31:0] i_addr,
   input  logic        i_we,
   input  logic [3:0]  i_be,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_busy
);

   localparam int unsigned AW = (SIZE > 1) ? $clog2(SIZE) : 1;

   logic [7:0]      mem_q [SIZE];
   logic [SIZE-1:0] wen_d;
   logic [7:0]      wbyte_d [SIZE];
   logic [31:0]     off0;

   // Offsets wrap modulo 2^32, so one unsigned compare covers both range bounds.
   assign off0   = i_addr - BASE;
   assign o_busy = 1'b0;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [31:0] off_k;
         assign off_k = off0 + 32'(gi);
         assign o_rdata[8*gi +: 8] = (off_k < SIZE) ? mem_q[off_k[AW-1:0]] : 8'h00;
      end

      // Each byte works out which lane (if any) targets it, so no lane-to-byte mux fan-in.
      for (gi = 0; gi < SIZE; gi++) begin : g_byte
         logic [31:0] delta;
         assign delta       = 32'(gi) - off0;
         assign wen_d[gi]   = i_we & (delta < 32'd4) & i_be[delta[1:0]];
         assign wbyte_d[gi] = 8'(i_wdata >> {delta[1:0], 3'b000});
      end
   endgenerate

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         for (int i = 0; i < int'(SIZE); i++) begin
            mem_q[i] <= 8'h00;
         end
      end else begin
         for (int i = 0; i < int'(SIZE); i++) begin
            if (wen_d[i]) begin
               mem_q[i] <= wbyte_d[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_final_mem.sv
// Self-checking bench for final_mem: two instances (BASE 0 and BASE 0x1000),
// directed steps followed by random traffic against a byte-array reference model.
module tb_final_mem;

   localparam int          SZ = 1024;
   localparam logic [31:0] B1 = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] addr_r  [2];
   logic        we_r    [2];
   logic [3:0]  be_r    [2];
   logic [31:0] wdata_r [2];
   logic [31:0] rdata_w [2];
   logic        busy_w  [2];

   logic [7:0]  model_m [2][SZ];
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   final_mem #(.BASE(32'h0), .SIZE(SZ)) u_mem0 (
      .i_clock(clk), .i_reset(rst_n), .i_addr(addr_r[0]), .i_we(we_r[0]),
      .i_be(be_r[0]), .i_wdata(wdata_r[0]), .o_rdata(rdata_w[0]), .o_busy(busy_w[0])
   );

   final_mem #(.BASE(B1), .SIZE(SZ)) u_mem1 (
      .i_clock(clk), .i_reset(rst_n), .i_addr(addr_r[1]), .i_we(we_r[1]),
      .i_be(be_r[1]), .i_wdata(wdata_r[1]), .o_rdata(rdata_w[1]), .o_busy(busy_w[1])
   );

   function automatic logic [63:0] base_of(int inst);
      return (inst == 1) ? {32'h0, B1} : 64'h0;
   endfunction

   function automatic logic [31:0] model_read(int inst, logic [31:0] a);
      logic [31:0] r;
      logic [63:0] base;
      logic [31:0] ak;
      r = 32'h0;
      base = base_of(inst);
      for (int k = 0; k < 4; k++) begin
         ak = a + 32'(k);
         if ({32'h0, ak} >= base && {32'h0, ak} < base + 64'(SZ))
            r[8*k +: 8] = model_m[inst][32'(ak - base[31:0])];
      end
      return r;
   endfunction

   task automatic model_write(int inst, logic [31:0] a, logic [3:0] be, logic [31:0] d);
      logic [63:0] base;
      logic [31:0] ak;
      base = base_of(inst);
      for (int k = 0; k < 4; k++) begin
         ak = a + 32'(k);
         if (be[k] && {32'h0, ak} >= base && {32'h0, ak} < base + 64'(SZ))
            model_m[inst][32'(ak - base[31:0])] = d[8*k +: 8];
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < SZ; j++)
            model_m[i][j] = 8'h00;
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-12s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Present a read address and compare after inputs settle (between edges).
   task automatic rd(int inst, logic [31:0] a, string tag, logic [31:0] exp);
      addr_r[inst] = a;
      we_r[inst] = 1'b0;
      #1;
      check(tag, rdata_w[inst], exp);
      check({tag, "_mdl"}, rdata_w[inst], model_read(inst, a));
   endtask

   // Drive a write at the falling edge, let the rising edge take it, then idle.
   task automatic wr(int inst, logic [31:0] a, logic [3:0] be, logic [31:0] d);
      @(negedge clk);
      addr_r[inst] = a;
      be_r[inst] = be;
      wdata_r[inst] = d;
      we_r[inst] = 1'b1;
      @(posedge clk);
      if (rst_n) model_write(inst, a, be, d);
      #1;
      we_r[inst] = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      logic        we;
      int          inst;

      for (int i = 0; i < 2; i++) begin
         addr_r[i] = 32'h8; we_r[i] = 1'b0; be_r[i] = 4'h0; wdata_r[i] = 32'h0;
      end
      model_clear();

      // Reset: storage clears, busy stays low.
      #1 rst_n = 1'b0;
      #2;
      check("rst_rd0", rdata_w[0], 32'h0);
      check("rst_busy0", {31'h0, busy_w[0]}, 32'h0);
      check("rst_busy1", {31'h0, busy_w[1]}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rd(0, 32'h0, "rst_base", 32'h0);
      rd(0, 32'h4, "rst_base4", 32'h0);
      rd(0, 32'(SZ - 4), "rst_top", 32'h0);
      rd(1, B1 + 32'(SZ - 4), "rst_top1", 32'h0);
      check("busy0", {31'h0, busy_w[0]}, 32'h0);

      // Full word, byte masks, unaligned straddle (BASE = 0).
      wr(0, 32'h8, 4'hF, 32'hDEADBEEF);
      rd(0, 32'h8, "word_rd8", 32'hDEADBEEF);
      rd(0, 32'h9, "word_rd9", 32'h00DEADBE);
      wr(0, 32'h8, 4'b0101, 32'h11223344);
      rd(0, 32'h8, "mask_rd8", 32'hDE22BE44);
      wr(0, 32'd14, 4'hF, 32'hA1B2C3D4);
      rd(0, 32'd12, "strad_rd12", 32'hC3D40000);
      rd(0, 32'd16, "strad_rd16", 32'h0000A1B2);
      wr(0, 32'h20, 4'h0, 32'hFFFFFFFF);
      rd(0, 32'h20, "be0_noop", 32'h0);

      // Wrap-around at the top of the address space and the memory's upper edge.
      wr(0, 32'h0, 4'hF, 32'h04030201);
      rd(0, 32'hFFFF_FFFE, "wrap_rd", 32'h02010000);
      wr(0, 32'(SZ - 2), 4'hF, 32'hCAFEF00D);
      rd(0, 32'(SZ - 4), "top_rd", 32'hF00D0000);

      // BASE offset and partial out-of-range.
      wr(1, 32'h13FE, 4'hF, 32'h55667788);
      rd(1, 32'h13FE, "oor_rd", 32'h00007788);
      rd(1, 32'h0FFC, "below_rd", 32'h0);
      wr(1, 32'h0, 4'hF, 32'h99999999);
      rd(1, 32'h1000, "oor_w0_lo", 32'h0);
      rd(1, 32'h13FC, "oor_w0_hi", 32'h77880000);

      // Random traffic: old data before the edge, new data after it.
      for (int n = 0; n < 400; n++) begin
         inst = int'($urandom_range(0, 1));
         if ($urandom_range(0, 9) != 0)
            a = 32'(base_of(inst)) + 32'($urandom_range(0, SZ + 8)) - 32'd4;
         else
            a = $urandom;
         d  = $urandom;
         be = 4'($urandom_range(0, 15));
         we = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         addr_r[inst] = a; be_r[inst] = be; wdata_r[inst] = d; we_r[inst] = we;
         #1;
         check("rnd_pre", rdata_w[inst], model_read(inst, a));
         @(posedge clk);
         if (we) model_write(inst, a, be, d);
         #1;
         check("rnd_post", rdata_w[inst], model_read(inst, a));
         we_r[inst] = 1'b0;
      end

      // Asynchronous reset between edges; a write sampled during reset is dropped.
      wr(0, 32'h40, 4'hF, 32'h12345678);
      rd(0, 32'h40, "pre_arst", 32'h12345678);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      check("arst_now", rdata_w[0], 32'h0);
      wr(0, 32'h40, 4'hF, 32'hAAAA5555);
      @(negedge clk);
      rst_n = 1'b1;
      rd(0, 32'h40, "arst_drop", 32'h0);
      wr(0, 32'h40, 4'h3, 32'hAAAA5555);
      rd(0, 32'h40, "post_rel_wr", 32'h00005555);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
